// File: rtl/interface_dt_bus_write.sv
// Z80-style external write cycle (T1, T2, TW*, T3) driven from the Dt mux byte.
// All bus outputs are flops loaded from the next-state decode, so strobes cannot glitch.
module interface_dt_bus_write #(
  parameter int IO_AUTO_WAIT = 1,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  selectedDt,
  input  logic [15:0] addr,
  input  logic        PI_WriteReq,
  input  logic        PI_WriteIO,
  input  logic        notWAIT,
  output logic [15:0] A,
  output logic [7:0]  Dout,
  output logic        Doe,
  output logic        notMREQ,
  output logic        notIORQ,
  output logic        notWR,
  output logic        busy,
  output logic        done,
  output logic        abort
);

  localparam int TCNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_MAX = '1;
  localparam logic [2:0] IO_WAITS = 3'(IO_AUTO_WAIT);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

  state_t              state_reg, state_next;
  logic                io_reg, io_next;
  logic [2:0]          wcnt_reg, wcnt_next;
  logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;
  logic [15:0]         a_next;
  logic [7:0]          d_next;
  logic                abort_next;

  always_comb begin
    state_next = state_reg;
    io_next    = io_reg;
    wcnt_next  = wcnt_reg;
    tcnt_next  = tcnt_reg;
    a_next     = A;
    d_next     = Dout;
    abort_next = 1'b0;
    case (state_reg)
      IDLE, T3: begin
        if (PI_WriteReq) begin
          state_next = T1;
          io_next    = PI_WriteIO;
          a_next     = addr;
          d_next     = selectedDt;
        end else begin
          state_next = IDLE;
        end
      end
      T1: state_next = T2;
      T2: begin
        wcnt_next  = io_reg ? IO_WAITS : 3'd0;
        tcnt_next  = '0;
        state_next = ((io_reg && IO_WAITS != 3'd0) || !notWAIT) ? TW : T3;
      end
      TW: begin
        if (wcnt_reg != 3'd0) begin
          // forced I/O wait; notWAIT only matters once the last forced cycle is reached
          wcnt_next = wcnt_reg - 3'd1;
          if (wcnt_reg == 3'd1 && notWAIT) state_next = T3;
        end else if (notWAIT) begin
          state_next = T3;
        end else begin
          if (tcnt_reg != TCNT_MAX) tcnt_next = tcnt_reg + 1'b1;
          if (WAIT_TIMEOUT != 0 && int'(tcnt_reg) + 1 == WAIT_TIMEOUT) begin
            abort_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      io_reg    <= 1'b0;
      wcnt_reg  <= 3'd0;
      tcnt_reg  <= '0;
      A         <= 16'h0000;
      Dout      <= 8'h00;
      Doe       <= 1'b0;
      notMREQ   <= 1'b1;
      notIORQ   <= 1'b1;
      notWR     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state_reg <= state_next;
      io_reg    <= io_next;
      wcnt_reg  <= wcnt_next;
      tcnt_reg  <= tcnt_next;
      A         <= a_next;
      Dout      <= d_next;
      Doe       <= (state_next != IDLE);
      busy      <= (state_next != IDLE);
      done      <= (state_next == T3);
      abort     <= abort_next;
      notMREQ   <= !(!io_next && (state_next inside {T1, T2, TW}));
      notIORQ   <= !(io_next && (state_next inside {T2, TW}));
      notWR     <= !(state_next inside {T2, TW});
    end
  end

endmodule

// File: tb/tb_interface_dt_bus_write.sv
// Randomized bench for interface_dt_bus_write; expected bus activity per cycle is derived
// from a closed-form count of wait states for each write.
module tb_interface_dt_bus_write;

  localparam int IO_AUTO_WAIT = 2;
  localparam int WAIT_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  selectedDt;
  logic [15:0] addr;
  logic        PI_WriteReq, PI_WriteIO, notWAIT;
  logic [15:0] A;
  logic [7:0]  Dout;
  logic        Doe, notMREQ, notIORQ, notWR, busy, done, abort;

  always #5 clk = ~clk;

  interface_dt_bus_write #(.IO_AUTO_WAIT(IO_AUTO_WAIT), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .selectedDt(selectedDt), .addr(addr),
    .PI_WriteReq(PI_WriteReq), .PI_WriteIO(PI_WriteIO), .notWAIT(notWAIT),
    .A(A), .Dout(Dout), .Doe(Doe), .notMREQ(notMREQ), .notIORQ(notIORQ),
    .notWR(notWR), .busy(busy), .done(done), .abort(abort)
  );

  wire [30:0] obs = {A, Dout, Doe, notMREQ, notIORQ, notWR, busy, done, abort};

  typedef enum {PH_T1, PH_T2, PH_TW, PH_T3, PH_ABORT, PH_IDLE, PH_RESET} phase_t;

  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] last_a;
  logic [7:0]  last_d;

  function automatic logic [30:0] expect_vec(phase_t ph, bit io, logic [15:0] a, logic [7:0] d);
    logic drv, mreq, iorq, wr;
    drv  = ph inside {PH_T1, PH_T2, PH_TW, PH_T3};
    mreq = !io && (ph inside {PH_T1, PH_T2, PH_TW});
    iorq = io && (ph inside {PH_T2, PH_TW});
    wr   = ph inside {PH_T2, PH_TW};
    if (ph == PH_RESET) begin
      a = 16'h0000;
      d = 8'h00;
    end
    return {a, d, drv, !mreq, !iorq, !wr, drv, ph == PH_T3, ph == PH_ABORT};
  endfunction

  task automatic check(input string tag, input logic [30:0] got, input logic [30:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // Runs one write; inputs are applied now and sampled on the next edge.
  // wait_low = number of cycles notWAIT is held low starting with the T2 cycle.
  task automatic run_txn(input bit io, input logic [15:0] a, input logic [7:0] d,
                         input int wait_low, input int rst_at, input string tag);
    int forced, ntw;
    bit aborted;
    phase_t ph;
    forced  = io ? IO_AUTO_WAIT : 0;
    ntw     = (forced > wait_low) ? forced : wait_low;
    aborted = (WAIT_TIMEOUT != 0) && (wait_low >= forced + WAIT_TIMEOUT + 1);
    if (aborted) ntw = forced + WAIT_TIMEOUT;
    $display("txn %s io=%0d a=%h d=%h wait_low=%0d tw=%0d abort=%0d",
             tag, io, a, d, wait_low, ntw, aborted);
    PI_WriteReq = 1'b1;
    PI_WriteIO  = io;
    addr        = a;
    selectedDt  = d;
    notWAIT     = 1'($urandom_range(1, 0));
    for (int c = 0; c < 3 + ntw; c++) begin
      @(posedge clk); #1;
      if (c == 0) ph = PH_T1;
      else if (c == 1) ph = PH_T2;
      else if (c < 2 + ntw) ph = PH_TW;
      else ph = aborted ? PH_ABORT : PH_T3;
      check($sformatf("%s c%0d", tag, c), obs, expect_vec(ph, io, a, d));
      last_a = a;
      last_d = d;
      if (c == rst_at) begin
        reset = 1'b1;
        PI_WriteReq = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s reset", tag), obs, expect_vec(PH_RESET, 1'b0, a, d));
        reset = 1'b0;
        last_a = 16'h0000;
        last_d = 8'h00;
        return;
      end
      if (c < 2 + ntw) begin
        // mid-cycle requests and input changes must be ignored
        PI_WriteReq = 1'($urandom_range(1, 0));
        PI_WriteIO  = 1'($urandom_range(1, 0));
        addr        = 16'($urandom);
        selectedDt  = 8'($urandom);
        notWAIT     = (c >= 1) ? ((c - 1) >= wait_low) : 1'($urandom_range(1, 0));
      end
    end
  endtask

  task automatic idle_cycle(input string tag);
    PI_WriteReq = 1'b0;
    PI_WriteIO  = 1'($urandom_range(1, 0));
    addr        = 16'($urandom);
    selectedDt  = 8'($urandom);
    notWAIT     = 1'($urandom_range(1, 0));
    @(posedge clk); #1;
    check(tag, obs, expect_vec(PH_IDLE, 1'b0, last_a, last_d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    PI_WriteReq = 1'b0;
    PI_WriteIO = 1'b0;
    addr = 16'h0000;
    selectedDt = 8'h00;
    notWAIT = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", obs, expect_vec(PH_RESET, 1'b0, 16'h0, 8'h0));
    reset = 1'b0;
    last_a = 16'h0000;
    last_d = 8'h00;

    run_txn(1'b0, 16'h1234, 8'hA5, 0, -1, "mem_nowait");
    idle_cycle("idle_mem");
    run_txn(1'b1, 16'h00F0, 8'h3C, 0, -1, "io_auto");
    idle_cycle("idle_io");
    run_txn(1'b0, 16'hBEEF, 8'h5A, 3, -1, "mem_wait3");
    idle_cycle("idle_wait");
    run_txn(1'b0, 16'h1111, 8'h11, 0, -1, "b2b_1");
    run_txn(1'b0, 16'h2222, 8'h22, 0, -1, "b2b_2");
    idle_cycle("idle_b2b");
    run_txn(1'b0, 16'hDEAD, 8'h77, 20, -1, "timeout");
    idle_cycle("idle_abort");
    run_txn(1'b1, 16'hCAFE, 8'h99, 20, 3, "reset_tw");
    idle_cycle("idle_rst");
    run_txn(1'b0, 16'h4321, 8'hC3, 0, -1, "after_rst");
    idle_cycle("idle_after");

    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom_range(1, 0)), 16'($urandom), 8'($urandom),
              int'($urandom_range(8, 0)), -1, $sformatf("rnd%0d", i));
      if ($urandom_range(1, 0) == 1) idle_cycle($sformatf("rnd%0d idle", i));
    end
    idle_cycle("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
